// File: rtl/mmu_l15_pkg.sv
// mmu_l15_pkg: shared types and helpers for mmu_l15_responder.
//   - state_e      : responder FSM states
//   - L15_SIZE_8B  : fixed 8-byte request size code
//   - RQ_* / RET_* : L1.5 request/return type codes (OpenPiton encodings)
//   - bswap64      : byte i <-> byte 7-i (little-endian <-> big-endian)
package mmu_l15_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [2:0] L15_SIZE_8B = 3'b011;

    localparam logic [4:0] RQ_LOAD    = 5'b00000;
    localparam logic [4:0] RQ_STORE   = 5'b00001;
    localparam logic [3:0] RET_LOAD   = 4'b0000;
    localparam logic [3:0] RET_ST_ACK = 4'b0100;

    function automatic logic [63:0] bswap64(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mmu_l15_responder.sv
// mmu_l15_responder: responder for the IOMMU page-table-walk memory port.
// Turns each single-outstanding MMU request (8B load or interrupt store)
// into one L1.5 transducer transaction and returns load data to the MMU.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mmu_val/ack/store/interrupt/address/data   MMU request side
//   mmu_rvalid, mmu_rdata        one-cycle response pulse + load data (LE)
//   transducer_l15_*             L1.5 request (data big-endian)
//   l15_transducer_*             L1.5 return; l15_transducer_ack consumes it
//   lat_o                        accept-to-response cycles of the last load
//
// Build option: MMU_L15_STORE_ACK_EN -- when defined, a store's ST_ACK
// produces an mmu_rvalid pulse with zero data; otherwise stores complete
// silently.
module mmu_l15_responder
    import mmu_l15_pkg::*;
#(
    parameter int unsigned PADDR_W = 40,
    parameter int unsigned LAT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mmu_val,
    output logic               mmu_ack,
    input  logic               mmu_store,
    input  logic               mmu_interrupt,
    input  logic [PADDR_W-1:0] mmu_address,
    input  logic [63:0]        mmu_data,
    output logic               mmu_rvalid,
    output logic [63:0]        mmu_rdata,
    output logic               transducer_l15_val,
    output logic [4:0]         transducer_l15_rqtype,
    output logic               transducer_l15_nc,
    output logic [2:0]         transducer_l15_size,
    output logic [PADDR_W-1:0] transducer_l15_address,
    output logic [63:0]        transducer_l15_data,
    input  logic               l15_transducer_header_ack,
    input  logic               l15_transducer_val,
    input  logic [3:0]         l15_transducer_returntype,
    input  logic [63:0]        l15_transducer_data_0,
    input  logic [63:0]        l15_transducer_data_1,
    output logic               l15_transducer_ack,
    output logic [LAT_W-1:0]   lat_o
);

    state_e             state_q, state_d;
    logic               store_q, store_d;
    logic               intr_q, intr_d;
    logic [PADDR_W-1:0] addr_q, addr_d;
    logic [63:0]        data_q, data_d;     // already byte-swapped
    logic [63:0]        rdata_q, rdata_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               req_active;

    function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        intr_d  = intr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        mmu_ack    = 1'b0;
        mmu_rvalid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mmu_val && !rst_i) begin
                    mmu_ack = 1'b1;
                    store_d = mmu_store;
                    intr_d  = mmu_interrupt;
                    addr_d  = mmu_address;
                    data_d  = bswap64(mmu_data);
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = sat_inc(cnt_q);
                if (l15_transducer_header_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = sat_inc(cnt_q);
                if (l15_transducer_val) begin
                    if (l15_transducer_returntype == RET_LOAD && !store_q) begin
                        rdata_d = bswap64(addr_q[3] ? l15_transducer_data_1
                                                    : l15_transducer_data_0);
                        state_d = ST_RESP;
                    end else if (l15_transducer_returntype == RET_ST_ACK && store_q) begin
`ifdef MMU_L15_STORE_ACK_EN
                        rdata_d = '0;
                        state_d = ST_RESP;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            ST_RESP: begin
                mmu_rvalid = 1'b1;
                // cnt_q counts cycles up to the one before RESP; the extra
                // increment makes lat_o span accept cycle to response cycle.
                if (!store_q) begin
                    lat_d = sat_inc(cnt_q);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            store_q <= 1'b0;
            intr_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            intr_q  <= intr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    // Request fields come straight from registers, so they stay stable for
    // as long as val is held; they read as zero when no request is open.
    assign req_active             = (state_q == ST_REQ);
    assign transducer_l15_val     = req_active;
    assign transducer_l15_rqtype  = req_active ? (store_q ? RQ_STORE : RQ_LOAD) : '0;
    assign transducer_l15_nc      = req_active && store_q && intr_q;
    assign transducer_l15_size    = req_active ? L15_SIZE_8B : '0;
    assign transducer_l15_address = req_active ? addr_q : '0;
    assign transducer_l15_data    = req_active ? data_q : '0;

    assign l15_transducer_ack = l15_transducer_val && !rst_i;
    assign mmu_rdata          = rdata_q;
    assign lat_o              = lat_q;

endmodule

// File: tb/tb_mmu_l15_responder.sv
module tb_mmu_l15_responder;

    localparam int unsigned PADDR_W = 40;
    localparam int unsigned LAT_W   = 16;
    localparam logic [3:0] RT_LOAD = 4'b0000;
    localparam logic [3:0] RT_STACK = 4'b0100;
    localparam logic [3:0] RT_INV  = 4'b0011;
    localparam logic [4:0] RQ_LD   = 5'b00000;
    localparam logic [4:0] RQ_ST   = 5'b00001;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               mmu_val, mmu_ack, mmu_store, mmu_interrupt;
    logic [PADDR_W-1:0] mmu_address;
    logic [63:0]        mmu_data;
    logic               mmu_rvalid;
    logic [63:0]        mmu_rdata;
    logic               transducer_l15_val;
    logic [4:0]         transducer_l15_rqtype;
    logic               transducer_l15_nc;
    logic [2:0]         transducer_l15_size;
    logic [PADDR_W-1:0] transducer_l15_address;
    logic [63:0]        transducer_l15_data;
    logic               l15_transducer_header_ack, l15_transducer_val;
    logic [3:0]         l15_transducer_returntype;
    logic [63:0]        l15_transducer_data_0, l15_transducer_data_1;
    logic               l15_transducer_ack;
    logic [LAT_W-1:0]   lat_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mmu_l15_responder #(.PADDR_W(PADDR_W), .LAT_W(LAT_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mmu_val(mmu_val), .mmu_ack(mmu_ack), .mmu_store(mmu_store),
        .mmu_interrupt(mmu_interrupt), .mmu_address(mmu_address), .mmu_data(mmu_data),
        .mmu_rvalid(mmu_rvalid), .mmu_rdata(mmu_rdata),
        .transducer_l15_val(transducer_l15_val), .transducer_l15_rqtype(transducer_l15_rqtype),
        .transducer_l15_nc(transducer_l15_nc), .transducer_l15_size(transducer_l15_size),
        .transducer_l15_address(transducer_l15_address), .transducer_l15_data(transducer_l15_data),
        .l15_transducer_header_ack(l15_transducer_header_ack),
        .l15_transducer_val(l15_transducer_val),
        .l15_transducer_returntype(l15_transducer_returntype),
        .l15_transducer_data_0(l15_transducer_data_0),
        .l15_transducer_data_1(l15_transducer_data_1),
        .l15_transducer_ack(l15_transducer_ack), .lat_o(lat_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           n_ack;
        int           n_rvalid;
        int           rt_cycles;
        int           n_lack_miss;
        int           n_val_late;
        bit           stable;
        logic [63:0]  rdata;
        logic [63:0]  td;
        logic [39:0]  ta;
        logic [4:0]   rq;
        logic         nc;
        logic [2:0]   sz;
    } obs_t;

    // Reference model: big-endian <-> little-endian is a full byte reversal.
    function automatic logic [63:0] swap_bytes(input logic [63:0] v);
        logic [63:0] r;
        r = {<<8{v}};
        return r;
    endfunction

    function automatic logic [63:0] ref_load(input logic [39:0] a, input logic [63:0] d0,
                                             input logic [63:0] d1);
        logic [63:0] sel;
        sel = a[3] ? d1 : d0;
        return swap_bytes(sel);
    endfunction

    function automatic logic [15:0] ref_lat(input int cycles);
        return (cycles > 65535) ? 16'hFFFF : cycles[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        mmu_val = 0; mmu_store = 0; mmu_interrupt = 0; mmu_address = '0; mmu_data = '0;
        l15_transducer_header_ack = 0; l15_transducer_val = 0;
        l15_transducer_returntype = '0; l15_transducer_data_0 = '0; l15_transducer_data_1 = '0;
    endtask

    // Drives one complete transaction and records what the DUT did.
    task automatic run_txn(input logic st, input logic intr, input logic [39:0] addr,
                           input logic [63:0] wdata, input logic [3:0] rtype,
                           input logic [63:0] d0, input logic [63:0] d1,
                           input int ha_delay, input int ret_delay,
                           input bit inv_first, input bit ret_with_ha, output obs_t o);
        int t0;
        t0 = 0;
        o.n_ack = 0; o.n_rvalid = 0; o.rt_cycles = -1; o.n_lack_miss = 0; o.n_val_late = 0;
        o.stable = 1; o.rdata = '0; o.td = '0; o.ta = '0; o.rq = '0; o.nc = 0; o.sz = '0;
        mmu_val = 1; mmu_store = st; mmu_interrupt = intr; mmu_address = addr; mmu_data = wdata;
        for (int k = 0; k < 20 && o.n_ack == 0; k++) begin
            if (k > 0) step();
            @(negedge clk);
            if (mmu_ack) begin o.n_ack += 1; t0 = cyc; end
        end
        step();
        mmu_val = 0; mmu_store = 1'($urandom); mmu_interrupt = 1'($urandom);
        mmu_address = {8'($urandom), 32'($urandom)}; mmu_data = {$urandom, $urandom};
        for (int k = 0; k <= ha_delay; k++) begin
            l15_transducer_header_ack = (k == ha_delay);
            if (k == ha_delay && ret_with_ha) begin
                l15_transducer_val = 1; l15_transducer_returntype = st ? RT_STACK : RT_LOAD;
                l15_transducer_data_0 = {$urandom, $urandom};
                l15_transducer_data_1 = {$urandom, $urandom};
            end
            @(negedge clk);
            if (mmu_ack) o.n_ack += 1;
            if (mmu_rvalid) o.n_rvalid += 1;
            if (!transducer_l15_val) o.stable = 0;
            if (k == 0) begin
                o.rq = transducer_l15_rqtype; o.nc = transducer_l15_nc;
                o.sz = transducer_l15_size; o.ta = transducer_l15_address;
                o.td = transducer_l15_data;
            end else if (o.rq !== transducer_l15_rqtype || o.nc !== transducer_l15_nc ||
                         o.sz !== transducer_l15_size || o.ta !== transducer_l15_address ||
                         o.td !== transducer_l15_data) begin
                o.stable = 0;
            end
            step();
            l15_transducer_header_ack = 0; l15_transducer_val = 0;
        end
        for (int k = 0; k <= ret_delay; k++) begin
            if (k == ret_delay) begin
                l15_transducer_val = 1; l15_transducer_returntype = rtype;
                l15_transducer_data_0 = d0; l15_transducer_data_1 = d1;
            end else if (k == 0 && inv_first) begin
                l15_transducer_val = 1; l15_transducer_returntype = RT_INV;
                l15_transducer_data_0 = {$urandom, $urandom};
                l15_transducer_data_1 = {$urandom, $urandom};
            end
            @(negedge clk);
            if (l15_transducer_val && !l15_transducer_ack) o.n_lack_miss += 1;
            if (transducer_l15_val) o.n_val_late += 1;
            if (mmu_rvalid) o.n_rvalid += 1;
            if (mmu_ack) o.n_ack += 1;
            step();
            l15_transducer_val = 0;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mmu_rvalid) begin o.n_rvalid += 1; o.rdata = mmu_rdata; o.rt_cycles = cyc - t0; end
            if (mmu_ack) o.n_ack += 1;
            step();
        end
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst_i = 1;
        mmu_val = 1;
        step(); step();
        @(negedge clk);
        checks++; if (mmu_ack !== 1'b0) begin errors++; $display("FAIL reset_mmu_ack: got %b expected 0", mmu_ack); end
        checks++; if (mmu_rvalid !== 1'b0 || mmu_rdata !== 64'h0) begin errors++; $display("FAIL reset_resp: rvalid %b rdata %h expected 0", mmu_rvalid, mmu_rdata); end
        checks++; if ({transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc, transducer_l15_size,
                       transducer_l15_address, transducer_l15_data} !== '0) begin
            errors++; $display("FAIL reset_l15_req: val %b addr %h data %h expected all 0", transducer_l15_val, transducer_l15_address, transducer_l15_data); end
        checks++; if (l15_transducer_ack !== 1'b0 || lat_o !== 16'h0) begin errors++; $display("FAIL reset_misc: l15_ack %b lat %h expected 0", l15_transducer_ack, lat_o); end
        step();
        rst_i = 0; mmu_val = 0;
        step();
    endtask

    task automatic test_load_basic();
        obs_t o;
        logic [39:0] a;
        a = 40'h0_8000_4008;
        run_txn(0, 0, a, 64'h0, RT_LOAD, 64'hDEAD_BEEF_0000_1111, 64'h0102030405060708, 0, 1, 0, 0, o);
        checks++; if (o.n_ack != 1) begin errors++; $display("FAIL load_ack_count: got %0d expected 1", o.n_ack); end
        checks++; if (o.rq !== RQ_LD || o.nc !== 1'b0 || o.sz !== 3'b011 || o.ta !== a) begin
            errors++; $display("FAIL load_req_fields: rq %h nc %b sz %b addr %h expected %h 0 011 %h", o.rq, o.nc, o.sz, o.ta, RQ_LD, a); end
        checks++; if (o.n_rvalid != 1) begin errors++; $display("FAIL load_rvalid_count: got %0d expected 1", o.n_rvalid); end
        checks++; if (o.rdata !== 64'h0807060504030201) begin errors++; $display("FAIL load_rdata: got %h expected 0807060504030201", o.rdata); end
        checks++; if (o.rt_cycles != 4) begin errors++; $display("FAIL load_roundtrip: got %0d expected 4", o.rt_cycles); end
        checks++; if (lat_o !== 16'd4) begin errors++; $display("FAIL load_lat: got %0d expected 4", lat_o); end
        checks++; if (o.n_lack_miss != 0 || o.n_val_late != 0) begin errors++; $display("FAIL load_handshake: ack_miss %0d val_late %0d expected 0 0", o.n_lack_miss, o.n_val_late); end
    endtask

    task automatic test_random_loads();
        obs_t o;
        logic [39:0] a;
        logic [63:0] d0, d1;
        int ha, rt;
        bit inv;
        for (int i = 0; i < 10; i++) begin
            a = {8'($urandom), 32'($urandom)};
            a[2:0] = '0;
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            ha = $urandom_range(0, 3);
            rt = $urandom_range(0, 3);
            inv = (rt > 0) && ($urandom_range(0, 1) == 1);
            run_txn(0, 1'($urandom), a, {$urandom, $urandom}, RT_LOAD, d0, d1, ha, rt, inv, 0, o);
            checks++; if (o.n_rvalid != 1 || o.rdata !== ref_load(a, d0, d1)) begin
                errors++; $display("FAIL rand_load_data[%0d]: rvalid %0d rdata %h expected 1 %h", i, o.n_rvalid, o.rdata, ref_load(a, d0, d1)); end
            checks++; if (o.rt_cycles != ha + rt + 3 || lat_o !== ref_lat(o.rt_cycles)) begin
                errors++; $display("FAIL rand_load_lat[%0d]: cycles %0d lat %0d expected %0d", i, o.rt_cycles, lat_o, ha + rt + 3); end
            checks++; if (o.ta !== a || o.rq !== RQ_LD || o.nc !== 1'b0) begin
                errors++; $display("FAIL rand_load_req[%0d]: addr %h rq %h nc %b expected %h %h 0", i, o.ta, o.rq, o.nc, a, RQ_LD); end
        end
    endtask

    task automatic test_store();
        obs_t o;
        logic [15:0] lat_before;
        lat_before = lat_o;
        run_txn(1, 1, 40'h0_9000_0010, 64'h8000_0000_0000_0042, RT_STACK, 64'h1, 64'h2, 0, 1, 0, 0, o);
        checks++; if (o.rq !== RQ_ST || o.nc !== 1'b1 || o.td !== 64'h4200_0000_0000_0080) begin
            errors++; $display("FAIL irq_store_req: rq %h nc %b data %h expected %h 1 4200000000000080", o.rq, o.nc, o.td, RQ_ST); end
`ifdef MMU_L15_STORE_ACK_EN
        checks++; if (o.n_rvalid != 1 || o.rdata !== 64'h0) begin errors++; $display("FAIL irq_store_resp: rvalid %0d rdata %h expected 1 0", o.n_rvalid, o.rdata); end
`else
        checks++; if (o.n_rvalid != 0) begin errors++; $display("FAIL irq_store_resp: rvalid %0d expected 0", o.n_rvalid); end
`endif
        checks++; if (lat_o !== lat_before) begin errors++; $display("FAIL store_lat_kept: got %0d expected %0d", lat_o, lat_before); end
        run_txn(1, 0, 40'h0_0000_0100, 64'h1122_3344_5566_7788, RT_STACK, 64'h0, 64'h0, 1, 0, 0, 0, o);
        checks++; if (o.rq !== RQ_ST || o.nc !== 1'b0 || o.td !== swap_bytes(64'h1122_3344_5566_7788)) begin
            errors++; $display("FAIL plain_store_req: rq %h nc %b data %h expected %h 0 %h", o.rq, o.nc, o.td, RQ_ST, swap_bytes(64'h1122_3344_5566_7788)); end
        checks++; if (o.n_ack != 1) begin errors++; $display("FAIL store_ack_count: got %0d expected 1", o.n_ack); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic [39:0] a;
        a = 40'h0_1234_5670;
        run_txn(0, 0, a, 64'h0, RT_LOAD, 64'hAABB_CCDD_EEFF_0011, 64'h5, 10, 2, 0, 1, o);
        checks++; if (!o.stable) begin errors++; $display("FAIL hold_fields_stable: got %0d expected 1", o.stable); end
        checks++; if (o.n_ack != 1) begin errors++; $display("FAIL hold_ack_once: got %0d expected 1", o.n_ack); end
        checks++; if (o.n_rvalid != 1 || o.rdata !== ref_load(a, 64'hAABB_CCDD_EEFF_0011, 64'h5)) begin
            errors++; $display("FAIL hold_rdata: rvalid %0d rdata %h expected 1 %h", o.n_rvalid, o.rdata, ref_load(a, 64'hAABB_CCDD_EEFF_0011, 64'h5)); end
        checks++; if (lat_o !== ref_lat(10 + 2 + 3)) begin errors++; $display("FAIL hold_lat: got %0d expected 15", lat_o); end
    endtask

    task automatic test_invalidation();
        obs_t o;
        run_txn(0, 0, 40'h0_0000_0048, 64'h0, RT_LOAD, 64'h7, 64'h0123_4567_89AB_CDEF, 0, 2, 1, 0, o);
        checks++; if (o.n_lack_miss != 0) begin errors++; $display("FAIL inv_acked: misses %0d expected 0", o.n_lack_miss); end
        checks++; if (o.n_rvalid != 1 || o.rdata !== 64'hEFCD_AB89_6745_2301) begin
            errors++; $display("FAIL inv_then_load: rvalid %0d rdata %h expected 1 efcdab8967452301", o.n_rvalid, o.rdata); end
    endtask

    task automatic test_mid_reset();
        int nrv;
        bit dirty;
        nrv = 0; dirty = 0;
        mmu_val = 1; mmu_store = 0; mmu_address = 40'h0_0000_0200;
        @(negedge clk); step(); mmu_val = 0;
        l15_transducer_header_ack = 1;
        @(negedge clk); step(); l15_transducer_header_ack = 0;
        rst_i = 1;
        @(negedge clk); step(); rst_i = 0;
        l15_transducer_val = 1; l15_transducer_returntype = RT_LOAD;
        l15_transducer_data_0 = 64'h1111_2222_3333_4444; l15_transducer_data_1 = 64'h5;
        @(negedge clk);
        checks++; if (l15_transducer_ack !== 1'b1) begin errors++; $display("FAIL rst_late_ret_ack: got %b expected 1", l15_transducer_ack); end
        step(); l15_transducer_val = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mmu_rvalid) nrv++;
            if (mmu_rdata !== '0 || lat_o !== '0 || transducer_l15_val || mmu_ack) dirty = 1;
            step();
        end
        checks++; if (nrv != 0) begin errors++; $display("FAIL rst_no_resp: rvalid %0d expected 0", nrv); end
        checks++; if (dirty) begin errors++; $display("FAIL rst_outputs_zero: rdata %h lat %h expected 0", mmu_rdata, lat_o); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] b;
        b = 40'h0_4444_0008;
        mmu_val = 1; mmu_store = 0; mmu_address = 40'h0_0000_0300;
        @(negedge clk); step(); mmu_val = 0;
        l15_transducer_header_ack = 1;
        @(negedge clk); step(); l15_transducer_header_ack = 0;
        l15_transducer_val = 1; l15_transducer_returntype = RT_LOAD; l15_transducer_data_0 = 64'h99;
        @(negedge clk); step(); l15_transducer_val = 0;
        mmu_val = 1; mmu_address = b;
        @(negedge clk);
        checks++; if (mmu_rvalid !== 1'b1 || mmu_ack !== 1'b0) begin errors++; $display("FAIL b2b_resp_no_ack: rvalid %b ack %b expected 1 0", mmu_rvalid, mmu_ack); end
        step();
        @(negedge clk);
        checks++; if (mmu_ack !== 1'b1 || mmu_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle_ack: ack %b rvalid %b expected 1 0", mmu_ack, mmu_rvalid); end
        step(); mmu_val = 0;
        @(negedge clk);
        checks++; if (transducer_l15_val !== 1'b1 || transducer_l15_address !== b) begin
            errors++; $display("FAIL b2b_second_req: val %b addr %h expected 1 %h", transducer_l15_val, transducer_l15_address, b); end
        l15_transducer_header_ack = 1;
        step(); l15_transducer_header_ack = 0;
        l15_transducer_val = 1; l15_transducer_data_1 = 64'hA1A2_A3A4_A5A6_A7A8;
        step(); l15_transducer_val = 0;
        @(negedge clk);
        checks++; if (mmu_rvalid !== 1'b1 || mmu_rdata !== ref_load(b, 64'h99, 64'hA1A2_A3A4_A5A6_A7A8)) begin
            errors++; $display("FAIL b2b_second_data: rvalid %b rdata %h expected 1 %h", mmu_rvalid, mmu_rdata, ref_load(b, 64'h99, 64'hA1A2_A3A4_A5A6_A7A8)); end
        step(); step();
    endtask

    task automatic test_saturation();
        obs_t o;
        run_txn(0, 0, 40'h0_0000_0040, 64'h0, RT_LOAD, 64'h55, 64'h66, 0, 70000, 0, 0, o);
        checks++; if (o.n_rvalid != 1 || o.rdata !== swap_bytes(64'h55)) begin errors++; $display("FAIL sat_data: rvalid %0d rdata %h expected 1 %h", o.n_rvalid, o.rdata, swap_bytes(64'h55)); end
        checks++; if (lat_o !== ref_lat(o.rt_cycles) || lat_o !== 16'hFFFF) begin errors++; $display("FAIL sat_lat: got %h expected ffff", lat_o); end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_random_loads();
        test_store();
        test_backpressure();
        test_invalidation();
        test_mid_reset();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmu_l15_responder.md
# mmu_l15_responder

Responder end of the IOMMU page-table-walk memory port: accepts single-outstanding 8-byte load and non-cacheable interrupt-store requests from `io_mmu`'s `l15_*` initiator port. Converts each request into one OpenPiton L1.5 transducer transaction and returns load data, and optionally store completions, to the MMU. Sits in the IS tile between `io_mmu` and the L1.5, alongside the tile's other L1.5 clients.

## Interface
Parameters:
- `PADDR_W`, 40, physical address width (`L15_PADDR_HI+1`)
- `LAT_W`, 16, width of the latency counter

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1, clock
- `rst_i` in 1, synchronous active-high reset
- `mmu_val` in 1, MMU request valid; held until `mmu_ack`
- `mmu_ack` out 1, request accepted
- `mmu_store` in 1, 1 = store, 0 = load
- `mmu_interrupt` in 1, store is an interrupt packet
- `mmu_address` in `PADDR_W`, byte address, 8B-aligned
- `mmu_data` in 64, store data, little-endian
- `mmu_rvalid` out 1, response pulse
- `mmu_rdata` out 64, load data, little-endian
- `transducer_l15_val` out 1, L1.5 request valid
- `transducer_l15_rqtype` out 5, `L15_RQTYPE` code
- `transducer_l15_nc` out 1, non-cacheable
- `transducer_l15_size` out 3, fixed 3'b011 (8B)
- `transducer_l15_address` out `PADDR_W`, request address
- `transducer_l15_data` out 64, store data, big-endian
- `l15_transducer_header_ack` in 1, L1.5 accepted the request
- `l15_transducer_val` in 1, L1.5 return valid
- `l15_transducer_returntype` in 4, return type
- `l15_transducer_data_0` in 64, return data
- `l15_transducer_data_1` in 64, return data
- `l15_transducer_ack` out 1, return consumed
- `lat_o` out `LAT_W`, cycles from accept to response of the last completed load

## Operation
- FSM: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If `mmu_val` is high: pulse `mmu_ack` (combinational, this cycle only), capture store/interrupt/address/data, clear the latency counter, go to REQ.
- REQ:
  - Drive `transducer_l15_val` from the registered fields:
    - load: rqtype `LOAD_RQ`, nc=0
    - store: rqtype `STORE_RQ`, nc=`mmu_interrupt`
  - On `l15_transducer_header_ack`, go to WAIT; val drops next cycle.
- WAIT:
  - `l15_transducer_ack` = `l15_transducer_val` in every state; every return is consumed in one cycle.
  - `LOAD_RET` while a load is pending: select `data_1` if address[3]=1, else `data_0`; byte-swap; register into `mmu_rdata`; go to RESP.
  - `ST_ACK` while a store is pending: go to RESP only with `MMU_L15_STORE_ACK_EN` (see Configuration).
  - Invalidations, mismatched types, and any return in IDLE/REQ/RESP: acked and dropped.
- RESP:
  - `mmu_rvalid`=1 for exactly one cycle; latch the latency counter into `lat_o` on loads; go to IDLE. New requests are not accepted in RESP.
- Byte swap: byte i ↔ byte 7-i, on store data out and load data in.
- Latency counter:
  - increments every cycle outside IDLE
  - saturates at all-ones; no wrap

## Timing
- Reset: FSM IDLE; all outputs 0, including `mmu_ack`, `mmu_rvalid`, `mmu_rdata`, `transducer_l15_val`, `l15_transducer_ack` and `lat_o`.
- `transducer_l15_val` rises the cycle after `mmu_ack`.
- Minimum load round trip: accept cycle 0, header_ack cycle 1, return cycle 2, `mmu_rvalid` cycle 3.
- `transducer_l15_*` fields are stable while val is high.
- Return in the same cycle as header_ack: ignored; only WAIT consumes returns.
- Reset mid-transaction: back to IDLE with no response. Returns arriving later are acked and dropped.
- `mmu_val` asserted in RESP: acked in the following IDLE cycle.

## Configuration
- `MMU_L15_STORE_ACK_EN` defined:
  - `ST_ACK` for a pending store takes WAIT→RESP; `mmu_rvalid` pulses with `mmu_rdata`=0.
  - `lat_o` unchanged.
- Undefined:
  - Stores complete silently on `ST_ACK` (WAIT→IDLE, no `mmu_rvalid`).

## Structure
- Package `mmu_l15_pkg`:
  - FSM state enum
  - `bswap64` function
  - size constant
  - RQTYPE/RETURNTYPE aliases onto the existing `l15.tmp.h` defines
- Single module; no sub-module needed.

## Test plan
- Load 0x0_8000_4008, L1.5 returns data_1=0x0102030405060708 two cycles after header_ack → `mmu_rdata`=0x0807060504030201, one-cycle `mmu_rvalid`, `lat_o`=4.
- Interrupt store, data 0x8000_0000_0000_0042 → rqtype `STORE_RQ`, nc=1, `transducer_l15_data`=0x4200_0000_0000_0080. On `ST_ACK`: `mmu_rvalid`+rdata 0 with the macro, none without.
- header_ack withheld 10 cycles → request fields held stable, `mmu_ack` pulsed once only.
- Invalidation return during WAIT, then `LOAD_RET` → invalidation acked and ignored; correct data delivered.
- `rst_i` asserted in WAIT, then `LOAD_RET` arrives → acked, no `mmu_rvalid`, all outputs 0.
- Load response delayed 70000 cycles → `lat_o`=0xFFFF (saturated).
